// File: rtl/freq_hist_stream.sv
// freq_hist_stream: per-block symbol frequency histogram for the Huffman front end.
// Counts each symbol of one input block into saturating counters, raises
// req_coding when the block ends, and after ack_coding streams the histogram
// out as one valid/ready beat per symbol in ascending index order.
// Optional build macro FREQ_SKIP_ZERO_EN: the readout skips zero-count symbols
// (one index scanned per cycle with rd_valid low) and rd_last marks the
// highest nonzero symbol.
module freq_hist_stream #(
    parameter int SYM_W   = 4,
    parameter int NUM_SYM = 10,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             data_valid,
    input  logic [SYM_W-1:0] data_in,
    input  logic             data_last,
    output logic             req_coding,
    input  logic             ack_coding,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_sym,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             rd_last,
    output logic             busy,
    output logic             overflow,
    output logic             bad_sym
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;
    localparam logic [1:0] S_DUMP  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYM - 1);

    // Saturating increment: a full counter keeps its value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt [NUM_SYM];
    logic             ovf_q;
    logic             bad_q;

    logic             count_en;
    logic             sym_hit;
    logic             ovf_hit;
    logic [CNT_W-1:0] sel_cnt;
    logic             beat_vld;
    logic             beat_last;
    logic             accept;
`ifdef FREQ_SKIP_ZERO_EN
    logic [IDX_W-1:0] last_nz;
`endif

    assign count_en = (state == S_COUNT) && data_valid;

    // Decode the incoming symbol, detect saturation, and select the readout counter.
    always_comb begin
        sym_hit = 1'b0;
        ovf_hit = 1'b0;
        sel_cnt = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (data_in == SYM_W'(i)) begin
                sym_hit = 1'b1;
                if (cnt[i] == CNT_MAX) ovf_hit = count_en;
            end
            if (idx == IDX_W'(i)) sel_cnt = cnt[i];
        end
    end

`ifdef FREQ_SKIP_ZERO_EN
    // Find the highest symbol with a nonzero count; it carries rd_last.
    always_comb begin
        last_nz = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            if (cnt[i] != '0) last_nz = IDX_W'(i);
        end
    end

    assign beat_vld  = (state == S_DUMP) && (sel_cnt != '0);
    assign beat_last = (idx == last_nz);
`else
    assign beat_vld  = (state == S_DUMP);
    assign beat_last = (idx == LAST_IDX);
`endif

    assign accept = beat_vld && rd_ready;

    // Control FSM: block framing, handshake with the coding stage, readout index and sticky flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_COUNT;
                        ovf_q <= 1'b0;
                        bad_q <= 1'b0;
                    end
                end
                S_COUNT: begin
                    if (data_valid) begin
                        if (!sym_hit) bad_q <= 1'b1;
                        if (ovf_hit)  ovf_q <= 1'b1;
                        if (data_last) state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_coding) begin
                        state <= S_DUMP;
                        idx   <= '0;
                    end
                end
                default: begin
`ifdef FREQ_SKIP_ZERO_EN
                    // A zero-count index is skipped without waiting for rd_ready.
                    if (accept && beat_last) begin
                        state <= S_IDLE;
                    end else if (accept || !beat_vld) begin
                        if (idx == LAST_IDX) state <= S_IDLE;
                        else                 idx   <= idx + IDX_W'(1);
                    end
`else
                    if (accept) begin
                        if (beat_last) state <= S_IDLE;
                        else           idx   <= idx + IDX_W'(1);
                    end
`endif
                end
            endcase
        end
    end

    // Per-symbol saturating counters, cleared by reset or by an accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SYM; i++) cnt[i] <= '0;
        end else if ((state == S_IDLE) && start) begin
            for (int i = 0; i < NUM_SYM; i++) cnt[i] <= '0;
        end else if (count_en) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                if (data_in == SYM_W'(i)) cnt[i] <= sat_inc(cnt[i]);
            end
        end
    end

    assign req_coding = (state == S_REQ);
    assign busy       = (state != S_IDLE);
    assign rd_valid   = beat_vld;
    assign rd_sym     = beat_vld ? idx : '0;
    assign rd_cnt     = beat_vld ? sel_cnt : '0;
    assign rd_last    = beat_vld && beat_last;
    assign overflow   = ovf_q;
    assign bad_sym    = bad_q;

endmodule

// File: tb/tb_freq_hist_stream.sv
// Bench for freq_hist_stream (default parameters): table-driven blocks with
// hand-derived histograms, hand-written corner sequences, and randomized
// blocks checked against a plain counting model.
module tb_freq_hist_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       data_valid;
    logic [3:0] data_in;
    logic       data_last;
    logic       req_coding;
    logic       ack_coding;
    logic       rd_valid;
    logic       rd_ready;
    logic [3:0] rd_sym;
    logic [7:0] rd_cnt;
    logic       rd_last;
    logic       busy;
    logic       overflow;
    logic       bad_sym;

    freq_hist_stream #(.SYM_W(4), .NUM_SYM(10), .CNT_W(8), .IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_valid(data_valid),
        .data_in(data_in), .data_last(data_last), .req_coding(req_coding),
        .ack_coding(ack_coding), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_sym(rd_sym), .rd_cnt(rd_cnt), .rd_last(rd_last), .busy(busy),
        .overflow(overflow), .bad_sym(bad_sym)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int blk[$];
    int exp_cnt[10];
    bit exp_ovf;
    bit exp_bad;

    // syms: nibble [0] is the first symbol; cnt: byte [i] is the count of symbol i.
    typedef struct {
        int              len;
        logic [7:0][3:0] syms;
        logic [9:0][7:0] cnt;
        bit              ovf;
        bit              bad;
        int              mode;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {req_coding, rd_valid, rd_sym, rd_cnt, rd_last, busy, overflow, bad_sym}, 0);
    endtask

    // Reference: count every symbol of the block, capped at 255.
    task automatic model_block();
        for (int s = 0; s < 10; s++) exp_cnt[s] = 0;
        exp_ovf = 0;
        exp_bad = 0;
        foreach (blk[i]) begin
            if (blk[i] >= 10) exp_bad = 1;
            else if (exp_cnt[blk[i]] == 255) exp_ovf = 1;
            else exp_cnt[blk[i]]++;
        end
    endtask

    // Drives one block from blk; rnd adds idle gaps and noise on ignored inputs.
    task automatic send_block(input bit rnd);
        @(negedge clk);
        start      = 1'b1;
        data_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        data_in    = 4'($urandom_range(0, 9));
        data_last  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < blk.size(); i++) begin
            while (rnd && $urandom_range(0, 3) == 0) begin
                data_valid = 1'b0;
                data_in    = 4'($urandom);
                data_last  = 1'($urandom_range(0, 1));
                start      = 1'($urandom_range(0, 1));
                ack_coding = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if (i == blk.size() - 1) chk("req_before_last", req_coding, 0);
            data_valid = 1'b1;
            data_in    = 4'(blk[i]);
            data_last  = (i == blk.size() - 1);
            start      = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            ack_coding = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
        end
        data_valid = 1'b0;
        data_last  = 1'b0;
        start      = 1'b0;
        ack_coding = 1'b0;
        chk("req_latency", req_coding, 1);
        chk("overflow_flag", overflow, 32'(exp_ovf));
        chk("bad_sym_flag", bad_sym, 32'(exp_bad));
    endtask

    // Handshake and readout; mode 0 ready always, 1 toggling, 2 random.
    task automatic dump_check(input int mode);
        int  q[$];
        int  k;
        int  cyc;
        bit  hold;
        logic [12:0] prev;
        for (int s = 0; s < 10; s++) begin
`ifdef FREQ_SKIP_ZERO_EN
            if (exp_cnt[s] != 0) q.push_back(s);
`else
            q.push_back(s);
`endif
        end
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            chk("req_held", req_coding, 1);
        end
        ack_coding = 1'b1;
        @(negedge clk);
        ack_coding = 1'b0;
        chk("req_drop", req_coding, 0);
        k    = 0;
        cyc  = 0;
        hold = 0;
        prev = '0;
        while (busy && cyc < 200) begin
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = cyc[0];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2) start = 1'($urandom_range(0, 1));
            if (rd_valid) begin
                if (hold) chk("beat_stable", {rd_sym, rd_cnt, rd_last}, prev);
                if (rd_ready) begin
                    if (k < q.size()) begin
                        chk("beat_sym", rd_sym, q[k]);
                        chk("beat_cnt", rd_cnt, exp_cnt[q[k]]);
                        chk("beat_last", rd_last, (k == q.size() - 1));
                    end else begin
                        chk("extra_beat", 1, 0);
                    end
                    k++;
                    hold = 0;
                end else begin
                    hold = 1;
                    prev = {rd_sym, rd_cnt, rd_last};
                end
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        rd_ready = 1'b0;
        chk("dump_end_idle", busy, 0);
        chk("idle_rd_valid", rd_valid, 0);
        chk("beat_count", k, q.size());
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; data_valid = 1'b0; data_in = '0;
        data_last = 1'b0; ack_coding = 1'b0; rd_ready = 1'b0;

        vecs[0] = '{len: 5, syms: 32'h0009_0733,
                    cnt: {8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd1},
                    ovf: 0, bad: 0, mode: 1};
        vecs[1] = '{len: 2, syms: 32'h0000_002C,
                    cnt: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0},
                    ovf: 0, bad: 1, mode: 0};
        vecs[2] = '{len: 1, syms: 32'h0000_0001,
                    cnt: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0},
                    ovf: 0, bad: 0, mode: 2};
        vecs[3] = '{len: 3, syms: 32'h0000_0BAF,
                    cnt: '0, ovf: 0, bad: 1, mode: 0};
        vecs[4] = '{len: 8, syms: 32'h7654_3210,
                    cnt: {8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},
                    ovf: 0, bad: 0, mode: 2};
        vecs[5] = '{len: 2, syms: 32'h0000_0084,
                    cnt: {8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0},
                    ovf: 0, bad: 0, mode: 1};

        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;

        // Table-driven blocks
        for (int v = 0; v < 6; v++) begin
            blk.delete();
            for (int i = 0; i < vecs[v].len; i++) blk.push_back(int'(vecs[v].syms[i]));
            for (int s = 0; s < 10; s++) exp_cnt[s] = int'(vecs[v].cnt[s]);
            exp_ovf = vecs[v].ovf;
            exp_bad = vecs[v].bad;
            send_block(0);
            dump_check(vecs[v].mode);
        end

        // 300 copies of symbol 5 saturate its counter
        blk.delete();
        repeat (300) blk.push_back(5);
        for (int s = 0; s < 10; s++) exp_cnt[s] = 0;
        exp_cnt[5] = 255;
        exp_ovf = 1;
        exp_bad = 0;
        send_block(0);
        dump_check(0);

        // Reset in the middle of a block, then a fresh one-symbol block
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_valid = 1'b1;
            data_in    = 4'(3 + i);
            @(negedge clk);
        end
        data_valid = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        chk_all_zero("mid_block_reset");
        rst_n = 1'b1;
        blk.delete();
        blk.push_back(1);
        for (int s = 0; s < 10; s++) exp_cnt[s] = 0;
        exp_cnt[1] = 1;
        exp_ovf = 0;
        exp_bad = 0;
        send_block(0);
        dump_check(0);

        // Randomized blocks against the counting model
        for (int b = 0; b < 25; b++) begin
            int len;
            blk.delete();
            len = $urandom_range(1, 40);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 7) == 0) blk.push_back($urandom_range(10, 15));
                else                           blk.push_back($urandom_range(0, 9));
            end
            model_block();
            send_block(1);
            dump_check(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
